// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one-outstanding req/ack
// fetches to instruction memory, buffers returned words and presents
// {pc, instr} to the decoder over valid/ready. Handles redirect flush and halt.
module instr_fetch_ctrl #(
  parameter int unsigned       ADDR_W    = 30,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dec_valid,
  output logic [31:0]       dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              dec_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  output logic [2:0]        buf_count
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pending_addr;
  logic [31:0]       instr_mem [BUF_DEPTH];
  logic [ADDR_W-1:0] pc_mem    [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [3:0]        count_ext;
  logic              push;
  logic              pop;
  logic              can_issue;

  // Buffer bookkeeping; a redirect voids any push/pop in the same cycle.
  // can_issue looks at the post-update occupancy so every issued request
  // already owns a free slot when its ack arrives.
  assign pop        = (count != '0) & dec_ready;
  assign push       = (state == REQ) & imem_ack & ~redirect_valid;
  assign count_next = redirect_valid ? '0
                                     : CNT_W'(count + CNT_W'(push) - CNT_W'(pop));
  assign can_issue  = ~halt & (count_next < CNT_W'(BUF_DEPTH));

  // Head of the buffer is the decoder interface; all of it comes from flops.
  assign dec_valid = (count != '0);
  assign dec_instr = instr_mem[rd_ptr];
  assign dec_pc    = pc_mem[rd_ptr];

  // Occupancy reported on a 3-bit port; saturates if the buffer is 8 deep.
  assign count_ext = 4'(count);
  assign buf_count = count_ext[3] ? 3'd7 : count_ext[2:0];

  // Fetch FSM: request issue, ack handling, redirect and flush of in-flight data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      pending_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) imem_addr <= redirect_addr;
          if (can_issue) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack) begin
            imem_addr <= redirect_valid ? redirect_addr : imem_addr + ADDR_W'(1);
            if (!can_issue) begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end else if (redirect_valid) begin
            pending_addr <= redirect_addr;
            state        <= FLUSH;
          end
        end
        FLUSH: begin
          if (imem_ack) begin
            imem_addr <= redirect_valid ? redirect_addr : pending_addr;
            if (can_issue) begin
              state <= REQ;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end else if (redirect_valid) begin
            pending_addr <= redirect_addr;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Fetch buffer: circular FIFO of {pc, instr}, emptied by a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr] <= imem_rdata;
        pc_mem[wr_ptr]    <= imem_addr;
        wr_ptr            <= PTR_W'(wr_ptr + 1'b1);
      end
      if (pop) rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Testbench for instr_fetch_ctrl: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_instr_fetch_ctrl;

  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [29:0] dec_pc;
  logic        dec_ready;
  logic        redirect_valid;
  logic [29:0] redirect_addr;
  logic        halt;
  logic [2:0]  buf_count;

  // Second instance starting at the top of the address space, free-running.
  logic        w_req;
  logic [29:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_dec_valid;
  logic [31:0] w_dec_instr;
  logic [29:0] w_dec_pc;
  logic        w_dec_ready;
  logic        w_redirect_valid;
  logic [29:0] w_redirect_addr;
  logic        w_halt;
  logic [2:0]  w_buf_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  ent_t        q[$];
  bit          m_req;
  bit          m_flush;
  logic [29:0] m_addr;
  logic [29:0] m_pend;

  instr_fetch_ctrl #(.ADDR_W(30), .RESET_PC(30'd0), .BUF_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halt(halt), .buf_count(buf_count)
  );

  instr_fetch_ctrl #(.ADDR_W(30), .RESET_PC(30'h3FFF_FFFF), .BUF_DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .dec_valid(w_dec_valid), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc), .dec_ready(w_dec_ready),
    .redirect_valid(w_redirect_valid), .redirect_addr(w_redirect_addr),
    .halt(w_halt), .buf_count(w_buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory contents: a distinct word per address.
  function automatic logic [31:0] word_of(input logic [29:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic model_reset();
    q.delete();
    m_req   = 1'b0;
    m_flush = 1'b0;
    m_addr  = 30'd0;
    m_pend  = 30'd0;
    cyc     = 0;
  endtask

  // One clock cycle: compare outputs, drive inputs, advance the model.
  task automatic step(input bit ack, input bit rdy, input bit redir,
                      input logic [29:0] raddr, input bit hlt);
    bit accepted;
    bit do_pop;
    bit was_req;
    bit was_flush;

    check("imem_req", 64'(imem_req), 64'(m_req));
    check("imem_addr", 64'(imem_addr), 64'(m_addr));
    check("dec_valid", 64'(dec_valid), 64'(q.size() != 0));
    check("buf_count", 64'(buf_count), 64'(q.size()));
    if (q.size() != 0) begin
      check("dec_pc", 64'(dec_pc), 64'(q[0].pc));
      check("dec_instr", 64'(dec_instr), 64'(q[0].instr));
    end
    case (cyc)
      0: begin
        check("wrap_req0", 64'(w_req), 64'(0));
        check("wrap_addr0", 64'(w_addr), 64'(30'h3FFF_FFFF));
      end
      1: begin
        check("wrap_req1", 64'(w_req), 64'(1));
        check("wrap_addr1", 64'(w_addr), 64'(30'h3FFF_FFFF));
      end
      2: begin
        check("wrap_addr2", 64'(w_addr), 64'(0));
        check("wrap_valid2", 64'(w_dec_valid), 64'(1));
        check("wrap_pc2", 64'(w_dec_pc), 64'(30'h3FFF_FFFF));
      end
      3: begin
        check("wrap_addr3", 64'(w_addr), 64'(1));
        check("wrap_pc3", 64'(w_dec_pc), 64'(0));
      end
      default: ;
    endcase

    accepted  = m_req && ack;
    do_pop    = (q.size() != 0) && rdy;
    was_req   = m_req;
    was_flush = m_flush;

    imem_ack       = accepted;
    imem_rdata     = accepted ? word_of(m_addr) : $urandom;
    dec_ready      = rdy;
    redirect_valid = redir;
    redirect_addr  = raddr;
    halt           = hlt;
    w_rdata        = word_of(w_addr);

    if (redir) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (accepted && !was_flush) q.push_back('{pc: m_addr, instr: word_of(m_addr)});
    end

    if (accepted) begin
      if (redir)          m_addr = raddr;
      else if (was_flush) m_addr = m_pend;
      else                m_addr = m_addr + 30'd1;
      m_flush = 1'b0;
    end else if (!was_req && redir) begin
      m_addr = raddr;
    end else if (was_req && redir) begin
      m_pend  = raddr;
      m_flush = 1'b1;
    end

    if (!was_req || accepted) m_req = !hlt && (q.size() < DEPTH);

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Bring the fetch engine to idle: complete any outstanding request under halt.
  task automatic go_idle();
    repeat (3) step(1'b1, 1'b1, 1'b0, 30'd0, 1'b1);
  endtask

  task automatic release_reset();
    imem_ack = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0;
    redirect_addr = '0; halt = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n            = 1'b0;
    w_ack            = 1'b1;
    w_dec_ready      = 1'b1;
    w_redirect_valid = 1'b0;
    w_redirect_addr  = '0;
    w_halt           = 1'b0;
    w_rdata          = '0;
    release_reset();

    // Streaming with memory acking every cycle and decoder always ready
    repeat (8) step(1'b1, 1'b1, 1'b0, 30'd0, 1'b0);

    // Backpressure: buffer fills, requests stop, then resume without loss
    repeat (6) step(1'b1, 1'b0, 1'b0, 30'd0, 1'b0);
    check("full_count", 64'(buf_count), 64'(2));
    check("full_req", 64'(imem_req), 64'(0));
    repeat (8) step(1'b1, 1'b1, 1'b0, 30'd0, 1'b0);

    // Redirect while a request is un-acked: its data is discarded
    go_idle();
    step(1'b0, 1'b1, 1'b1, 30'd5, 1'b0);
    step(1'b0, 1'b1, 1'b1, 30'h40, 1'b0);
    step(1'b0, 1'b1, 1'b0, 30'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 30'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 30'd0, 1'b0);
    check("flush_next_addr", 64'(imem_addr), 64'(30'h40));
    repeat (4) step(1'b1, 1'b1, 1'b0, 30'd0, 1'b0);

    // Redirect coincident with an ack while one entry is buffered
    go_idle();
    step(1'b0, 1'b0, 1'b1, 30'd6, 1'b0);
    step(1'b1, 1'b0, 1'b0, 30'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 30'h80, 1'b0);
    check("redir_empty", 64'(buf_count), 64'(0));
    check("redir_addr", 64'(imem_addr), 64'(30'h80));
    repeat (4) step(1'b1, 1'b1, 1'b0, 30'd0, 1'b0);

    // Halt during an outstanding request
    step(1'b0, 1'b1, 1'b0, 30'd0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 30'd0, 1'b1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 30'd0, 1'b1);
    check("halt_no_req", 64'(imem_req), 64'(0));
    repeat (4) step(1'b1, 1'b1, 1'b0, 30'd0, 1'b0);

    // Random traffic with a reset pulse in the middle
    for (int i = 0; i < 3000; i++) begin
      logic [29:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 30'(30'h3FFF_FFFC + 30'($urandom_range(0, 3)))
                                       : 30'($urandom);
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 8, ra, $urandom_range(0, 9) == 0);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_req", 64'(imem_req), 64'(0));
        check("rst_valid", 64'(dec_valid), 64'(0));
        check("rst_addr", 64'(imem_addr), 64'(0));
        check("rst_wrap_addr", 64'(w_addr), 64'(30'h3FFF_FFFF));
        release_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
